// File: rtl/burst_sp_memory.sv
// burst_sp_memory: single-port synchronous RAM with a command-driven burst engine.
// One command (direction, start address, beat count) moves that many beats over
// valid/ready streams, with wrap-around address increment. Read data passes through
// a 2-entry skid buffer so the consumer can stall without losing beats.
// Optional feature macro: BURST_MEM_PARITY_EN (adds an even-parity bit per word
// and reports mismatches on o_rd_err).
module burst_sp_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_rd_err,
  output logic                  o_busy,
  output logic                  o_done
);

`ifdef BURST_MEM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  iss_rem_q, iss_rem_d;   // reads still to issue / writes still to accept
  logic [LEN_WIDTH-1:0]  beat_rem_q, beat_rem_d; // read beats still to hand to the consumer

  logic [MW-1:0]         mem_q [DEPTH];
  logic [MW-1:0]         rdata_q;
  logic [MW-1:0]         wr_word;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_err_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;

  logic                  cmd_hs, wr_hs, rd_pop, issue, push, push_err;
  logic [2:0]            occ;

`ifdef BURST_MEM_PARITY_EN
  assign wr_word  = {^i_wr_data, i_wr_data};
  // Stored bit is even parity of the data, so the XOR of the whole word is 0 when intact.
  assign push_err = ^rdata_q;
`else
  assign wr_word  = i_wr_data;
  assign push_err = 1'b0;
`endif

  assign cmd_hs = (state_q == IDLE) && i_cmd_valid;
  assign wr_hs  = (state_q == WRITE) && i_wr_valid;
  assign rd_pop = (state_q == READ) && (cnt_q != 2'd0) && i_rd_ready;
  assign push   = inflight_q;
  // Occupancy the buffer would have if nothing new were issued: the issue guard
  // keeps buffered plus in-flight beats at most 2, so the skid buffer never overflows.
  assign occ    = 3'(cnt_q) + 3'(inflight_q) - 3'(rd_pop);
  assign issue  = (state_q == READ) && (iss_rem_q != '0) && (occ < 3'd2);
  assign cnt_d  = cnt_q + 2'(push) - 2'(rd_pop);

  assign o_cmd_ready = (state_q == IDLE);
  assign o_wr_ready  = (state_q == WRITE);
  assign o_rd_valid  = (state_q == READ) && (cnt_q != 2'd0);
  assign o_rd_data   = buf_data_q[rd_ptr_q];
  assign o_rd_last   = o_rd_valid && (beat_rem_q == LEN_WIDTH'(1));
  assign o_rd_err    = o_rd_valid && buf_err_q[rd_ptr_q];
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);

  // Next-state and counter update for the burst FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_rem_d  = iss_rem_q;
    beat_rem_d = beat_rem_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d     = i_cmd_addr;
          iss_rem_d  = i_cmd_len;
          beat_rem_d = i_cmd_len;
          if (i_cmd_len == '0) state_d = DONE;
          else if (i_cmd_write) state_d = WRITE;
          else state_d = READ;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          addr_d    = addr_q + ADDR_WIDTH'(1);
          iss_rem_d = iss_rem_q - LEN_WIDTH'(1);
          if (iss_rem_q == LEN_WIDTH'(1)) state_d = DONE;
        end
      end
      READ: begin
        if (issue) begin
          addr_d    = addr_q + ADDR_WIDTH'(1);
          iss_rem_d = iss_rem_q - LEN_WIDTH'(1);
        end
        if (rd_pop) begin
          beat_rem_d = beat_rem_q - LEN_WIDTH'(1);
          if (beat_rem_q == LEN_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and burst counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      iss_rem_q  <= '0;
      beat_rem_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_rem_q  <= iss_rem_d;
      beat_rem_q <= beat_rem_d;
    end
  end

  // Storage array: not reset, so contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (wr_hs) mem_q[addr_q] <= wr_word;
    if (issue) rdata_q <= mem_q[addr_q];
  end

  // Read pipeline tracking and 2-entry skid buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_q    <= 1'b0;
      cnt_q         <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_err_q     <= '0;
    end else begin
      inflight_q <= issue;
      cnt_q      <= cnt_d;
      if (push) begin
        buf_data_q[wr_ptr_q] <= rdata_q[DATA_WIDTH-1:0];
        buf_err_q[wr_ptr_q]  <= push_err;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (rd_pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_burst_sp_memory.sv
// Self-checking bench for burst_sp_memory: directed vector table, hand-written
// corner sequences and randomized bursts checked against a flat memory model.
module tb_burst_sp_memory;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic       i_cmd_write = 1'b0;
  logic [7:0] i_cmd_addr = '0;
  logic [7:0] i_cmd_len = '0;
  logic       i_wr_valid = 1'b0;
  logic       o_wr_ready;
  logic [7:0] i_wr_data = '0;
  logic       o_rd_valid;
  logic       i_rd_ready = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_last;
  logic       o_rd_err;
  logic       o_busy;
  logic       o_done;

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_mem [256];
  bit         ref_err [256];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    int         mode;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  burst_sp_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_rd_last(o_rd_last), .o_rd_err(o_rd_err), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got hang, expected completion)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_wr_ready", o_wr_ready, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_rd_last", o_rd_last, 0);
    check("rst_rd_err", o_rd_err, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rd_data", o_rd_data, 0);
  endtask

  // Called at a negedge; returns at the negedge right after the command handshake.
  task automatic send_cmd(input bit w, input logic [7:0] a, input int l);
    int n = 0;
    i_cmd_valid = 1'b1;
    i_cmd_write = w;
    i_cmd_addr  = a;
    i_cmd_len   = 8'(l);
    while (!o_cmd_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("cmd_accept_ready", o_cmd_ready, 1);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic idle_chk();
    @(negedge i_clk);
    check("post_done_low", o_done, 0);
    check("post_cmd_ready", o_cmd_ready, 1);
    check("post_busy", o_busy, 0);
  endtask

  task automatic write_data(input logic [7:0] a, input int l, input int nbeats, input bit rnd,
                            input logic [7:0] base, input logic [7:0] step, input bit gaps);
    int k = 0;
    int n = 0;
    logic [7:0] ea;
    while (k < nbeats && n < 2000) begin
      check("wr_cmd_ready_low", o_cmd_ready, 0);
      check("wr_rd_valid_low", o_rd_valid, 0);
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_wr_valid = 1'b0;
      end else begin
        i_wr_valid = 1'b1;
        i_wr_data  = rnd ? 8'($urandom) : 8'(base + k * step);
      end
      if (i_wr_valid && o_wr_ready) begin
        ea = 8'(a + k);
        ref_mem[ea] = i_wr_data;
        ref_err[ea] = 1'b0;
        k++;
      end
      @(negedge i_clk);
      n++;
    end
    i_wr_valid = 1'b0;
    check("wr_beats_accepted", k, nbeats);
    if (nbeats == l) begin
      check("wr_done_pulse", o_done, 1);
      check("wr_done_wr_ready", o_wr_ready, 0);
      check("wr_done_cmd_ready", o_cmd_ready, 0);
    end
  endtask

  // Called at the negedge right after the command handshake.
  task automatic read_data(input logic [7:0] a, input int l, input int mode, input bit chk,
                           input logic [7:0] ef, input logic [7:0] el);
    int k = 0;
    int cyc = 1;
    int first = -1;
    int pi = 0;
    bit stall = 0;
    bit r;
    logic [7:0] sd;
    logic sl, se;
    logic [7:0] ea;
    logic [5:0] pat;
    pat = 6'b101001;
    while (k < l && cyc < 2000) begin
      if (o_rd_valid) begin
        if (first < 0) first = cyc;
        if (stall) begin
          check("stall_data", o_rd_data, sd);
          check("stall_last", o_rd_last, sl);
          check("stall_err", o_rd_err, se);
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom_range(0, 1));
          default: begin r = pat[pi % 6]; pi++; end
        endcase
        i_rd_ready = r;
        if (r) begin
          ea = 8'(a + k);
          check("rd_data", o_rd_data, ref_mem[ea]);
          check("rd_last", o_rd_last, (k == l - 1) ? 1 : 0);
          check("rd_err", o_rd_err, ref_err[ea]);
          if (chk && k == 0) check("rd_first_vec", o_rd_data, ef);
          if (chk && k == l - 1) check("rd_last_vec", o_rd_data, el);
          k++;
          stall = 0;
        end else begin
          stall = 1;
          sd = o_rd_data;
          sl = o_rd_last;
          se = o_rd_err;
        end
      end else begin
        if (stall) check("stall_valid_held", o_rd_valid, 1);
        stall = 0;
        i_rd_ready = 1'($urandom_range(0, 1));
      end
      @(negedge i_clk);
      cyc++;
    end
    i_rd_ready = 1'b0;
    check("rd_beats_delivered", k, l);
    check("rd_latency", first, 3);
    if (mode == 0) check("rd_no_bubble", cyc - first, l);
    check("rd_done_pulse", o_done, 1);
    check("rd_done_cmd_ready", o_cmd_ready, 0);
    check("rd_done_valid", o_rd_valid, 0);
  endtask

  task automatic run_burst(input bit wr, input logic [7:0] a, input int l, input bit rnd,
                           input logic [7:0] base, input logic [7:0] step, input int mode,
                           input bit chk, input logic [7:0] ef, input logic [7:0] el);
    send_cmd(wr, a, l);
    check("burst_busy", o_busy, 1);
    if (l == 0) begin
      check("len0_done", o_done, 1);
      check("len0_wr_ready", o_wr_ready, 0);
      check("len0_rd_valid", o_rd_valid, 0);
      check("len0_cmd_ready", o_cmd_ready, 0);
    end else if (wr) begin
      write_data(a, l, l, rnd, base, step, mode != 0);
    end else begin
      read_data(a, l, mode, chk, ef, el);
    end
    idle_chk();
  endtask

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 8'h01, len: 8, base: 8'hA0, step: 8'h01, mode: 0, exp_first: 8'h00, exp_last: 8'h00};
    vecs[1] = '{wr: 1'b0, addr: 8'h01, len: 8, base: 8'h00, step: 8'h00, mode: 0, exp_first: 8'hA0, exp_last: 8'hA7};
    vecs[2] = '{wr: 1'b1, addr: 8'hFE, len: 4, base: 8'h11, step: 8'h11, mode: 0, exp_first: 8'h00, exp_last: 8'h00};
    vecs[3] = '{wr: 1'b0, addr: 8'h00, len: 2, base: 8'h00, step: 8'h00, mode: 0, exp_first: 8'h33, exp_last: 8'h44};
    vecs[4] = '{wr: 1'b0, addr: 8'hFE, len: 4, base: 8'h00, step: 8'h00, mode: 0, exp_first: 8'h11, exp_last: 8'h44};
    vecs[5] = '{wr: 1'b0, addr: 8'h02, len: 6, base: 8'h00, step: 8'h00, mode: 2, exp_first: 8'hA1, exp_last: 8'hA6};
    vecs[6] = '{wr: 1'b1, addr: 8'h20, len: 0, base: 8'h00, step: 8'h00, mode: 0, exp_first: 8'h00, exp_last: 8'h00};
    vecs[7] = '{wr: 1'b0, addr: 8'h30, len: 0, base: 8'h00, step: 8'h00, mode: 0, exp_first: 8'h00, exp_last: 8'h00};

    for (int i = 0; i < 256; i++) ref_err[i] = 1'b0;

    // Reset state.
    #12;
    check_reset_outputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Fill the whole array so every later read has a known model value (max-length burst).
    run_burst(1'b1, 8'h00, 255, 1'b1, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00);
    run_burst(1'b1, 8'hFF, 1, 1'b1, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, 1'b0, vecs[i].base, vecs[i].step,
                vecs[i].mode, 1'b1, vecs[i].exp_first, vecs[i].exp_last);
    end

    // Command held valid during a write burst is accepted only after DONE.
    send_cmd(1'b1, 8'h60, 3);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 8'h60;
    i_cmd_len   = 8'd3;
    write_data(8'h60, 3, 3, 1'b1, 8'h00, 8'h00, 1'b0);
    @(negedge i_clk);
    check("held_cmd_ready", o_cmd_ready, 1);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    read_data(8'h60, 3, 0, 1'b0, 8'h00, 8'h00);
    idle_chk();

    // Reset after 3 of 8 write beats.
    send_cmd(1'b1, 8'h40, 8);
    write_data(8'h40, 8, 3, 1'b1, 8'h00, 8'h00, 1'b0);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_burst(1'b0, 8'h40, 8, 1'b0, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00);

`ifdef BURST_MEM_PARITY_EN
    // Corrupt one stored data bit, leaving the parity bit alone.
    dut.mem_q[8'h10] = dut.mem_q[8'h10] ^ 9'h001;
    ref_mem[8'h10] = ref_mem[8'h10] ^ 8'h01;
    ref_err[8'h10] = 1'b1;
    run_burst(1'b0, 8'h10, 1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    run_burst(1'b0, 8'h11, 1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    run_burst(1'b0, 8'h0F, 3, 1'b0, 8'h00, 8'h00, 2, 1'b0, 8'h00, 8'h00);
`endif

    // Randomized bursts against the model.
    for (int i = 0; i < 30; i++) begin
      bit         w;
      logic [7:0] a;
      int         l;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      run_burst(w, a, l, 1'b1, 8'h00, 8'h00, int'($urandom_range(0, 2)), 1'b0, 8'h00, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
